rec_df_ram1_reader: RTL and testbench
=====================================

Name: rec_DF_RAM1_reader

Overview:
Deblocking-filter-side read controller for the 96x32 reconstruction-to-DF macroblock buffer. When reconstruction signals that a complete macroblock has been written, the block reads all 96 words in order:
- words 0-63: luma, 16x16 pixels
- words 64-79: Cb
- words 80-95: Cr

It streams the words to the deblocking filter over a valid/ready interface and pulses done when the buffer may be overwritten. A small skid FIFO absorbs the RAM read latency, so filter backpressure never loses data.

Parameters:
- NUM_WORDS, 96, words per macroblock buffer
- LUMA_WORDS, 64, words tagged as luma
- CB_WORDS, 16, words tagged Cb; the remaining words are tagged Cr
- FIFO_DEPTH, 4, skid FIFO entries; power of 2, minimum 2
- ADDR_W, 7, RAM address width

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mb_start  in  1  one-cycle pulse: buffer holds a complete macroblock
- busy  out  1  high from the accepted mb_start until the mb_done cycle inclusive
- start_err  out  1  one-cycle pulse: mb_start arrived while busy
- mb_done  out  1  one-cycle pulse: last word accepted by DF; buffer is free
- ram_cs_n  out  1  RAM chip select, active low
- ram_wr  out  1  RAM write enable; tied 0
- ram_addr  out  ADR_W  RAM word address
- ram_dout  in  32  RAM read data
- df_valid  out  1  df_data is valid
- df_ready  in  1  DF accepts the word this cycle
- df_data  out  32  four packed 8-bit pixels; byte0 is the leftmost pixel
- df_word_idx  out  7  buffer address of df_data (0..95)
- df_comp  out  2  component tag: 0=Y, 1=Cb, 2=Cr
- df_last  out  1  df_word_idx==NUM_WORDS-1

Behaviour:
- Reset values: busy=0, start_err=0, mb_done=0, ram_cs_n=1, ram_wr=0, ram_addr=0, df_valid=0, df_data=0, df_word_idx=0, df_comp=0, df_last=0. The FIFO, counters and FSM (state IDLE) are cleared.
- Reset mid-burst aborts immediately: no mb_done is pulsed and the outputs take their reset values.
- RAM port timing is fixed by the buffer wrapper:
  - The first cs_n=0, wr=0 cycle only arms the output enable (the prime cycle). No data results from it.
  - While cs_n stays low, the address presented in cycle n appears on ram_dout in cycle n+1.
  - Any cycle with cs_n=1 disarms the output enable; the next read needs a new prime cycle.
- FSM states:
  - IDLE: on mb_start, set busy=1, rd_ptr=0, go to PRIME.
  - PRIME: ram_cs_n=0, ram_addr=rd_ptr. Go to ISSUE.
  - ISSUE:
    - If credit is available: ram_cs_n=0, ram_addr=rd_ptr, rd_ptr++, and the word is marked in flight for next-cycle capture.
    - Credit is available when fifo_count + inflight < FIFO_DEPTH, where inflight is 0 or 1.
    - If no credit: ram_cs_n=1, go to STALL.
    - After issuing rd_ptr==NUM_WORDS-1, go to DRAIN.
  - STALL: ram_cs_n=1. When credit returns, go to PRIME.
  - DRAIN: ram_cs_n=1. Wait until the FIFO is empty and the last word has been accepted, then go to DONE.
  - DONE: mb_done=1 for one cycle, busy=0 in the following cycle, go to IDLE.
- Capture: the in-flight word is written to the FIFO together with its address. df_comp is derived from that address: <64 gives Y, <80 gives Cb, otherwise Cr.
- FIFO output drives df_* directly. df_valid = !empty.
- Pop on df_valid&&df_ready; a capture in the same cycle is allowed. Because of credit accounting the FIFO never overflows; overflow is an assertion failure.
- df_data and the tags hold stable while df_valid=1 and df_ready=0.
- Throughput with df_ready held high: one word per cycle after a latency of 3 cycles from mb_start to the first df_valid (PRIME, ISSUE, capture).
- mb_start while busy: ignored, start_err pulses for one cycle, the burst is unaffected.
- mb_start in the DONE cycle is also ignored and flagged.
- Words are always delivered in strictly ascending address order with no gaps or duplicates.

Decomposition:
- Shared package rec_DF_pkg holds:
  - constants NUM_WORDS, LUMA_WORDS, CB_WORDS
  - component encodings COMP_Y, COMP_CB, COMP_CR
  - FSM state encodings
- One sub-module, rec_DF_skid_fifo: synchronous FIFO of FIFO_DEPTH entries, 41 bits wide (data, idx, comp). It provides push, pop, count, empty and full.

Test Plan:
- Full stream, df_ready=1: RAM preloaded with word k = {k,k,k,k} bytes. One mb_start gives exactly 96 transfers with data = {k,k,k,k}. The first df_valid is 3 cycles after mb_start, df_last is only at idx 95, and mb_done comes 1 cycle after the idx-95 transfer.
- Component tagging: df_comp is 0 for idx 0-63, 1 for idx 64-79 and 2 for idx 80-95; each boundary is checked at 63/64 and 79/80.
- Backpressure: df_ready=0 for 10 cycles starting mid-luma. Within 2 cycles ram_cs_n goes high with 4 words held. No loss or duplication occurs, a new PRIME follows the ready release, and the sequence stays 0..95.
- Random df_ready at 30% duty: a scoreboard sees all 96 words in order, the FIFO count never exceeds 4, and mb_done appears exactly once.
- mb_start at word 40: start_err pulses once and the stream completes unchanged. A later mb_start after mb_done starts a second clean burst.
- Reset asserted at word 50: all outputs return to reset values asynchronously and no mb_done is pulsed. A new mb_start after release streams from idx 0.

Source files
------------

// File: rtl/rec_df_ram1_reader_pkg.sv
// Shared definitions for the reconstruction-to-DF buffer reader.
//   - Macroblock buffer geometry (luma / Cb / Cr word counts)
//   - Component tag encoding carried alongside each streamed word
//   - Reader FSM state encoding
//   - Skid FIFO entry layout (32-bit data, 7-bit index, 2-bit tag = 41 bits)
package rec_df_ram1_reader_pkg;

    localparam int unsigned NUM_WORDS  = 96;
    localparam int unsigned LUMA_WORDS = 64;
    localparam int unsigned CB_WORDS   = 16;
    localparam int unsigned IDX_W      = 7;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        ISSUE,
        STALL,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
        comp_t            comp;
    } fifo_entry_t;

    function automatic comp_t comp_of(input int unsigned idx,
                                      input int unsigned luma_words,
                                      input int unsigned cb_words);
        if (idx < luma_words)
            return COMP_Y;
        else if (idx < luma_words + cb_words)
            return COMP_CB;
        return COMP_CR;
    endfunction

endpackage

// File: rtl/rec_df_ram1_reader_if.sv
// Word stream from the buffer reader to the deblocking filter.
//   df_valid    : df_data and tags are valid
//   df_ready    : filter accepts the word this cycle
//   df_data     : four packed 8-bit pixels, byte0 leftmost
//   df_word_idx : buffer address of df_data (0..95)
//   df_comp     : component tag (Y / Cb / Cr)
//   df_last     : final word of the macroblock
// master = reader side, slave = filter side.
interface rec_df_ram1_reader_if;
    import rec_df_ram1_reader_pkg::*;

    logic             df_valid;
    logic             df_ready;
    logic [31:0]      df_data;
    logic [IDX_W-1:0] df_word_idx;
    comp_t            df_comp;
    logic             df_last;

    modport master (
        output df_valid, df_data, df_word_idx, df_comp, df_last,
        input  df_ready
    );

    modport slave (
        input  df_valid, df_data, df_word_idx, df_comp, df_last,
        output df_ready
    );
endinterface

// File: rtl/rec_df_ram1_reader_skid_fifo.sv
// Small synchronous FIFO absorbing the one-cycle RAM read latency.
//   clk, reset : clock, asynchronous active-high reset
//   push/wr_entry : write an entry (caller guarantees space)
//   pop/rd_entry  : head entry is always visible on rd_entry; pop advances
//   count, empty, full : occupancy status
// Storage is cleared on reset so the head reads as all-zero afterwards.
module rec_df_ram1_reader_skid_fifo
    import rec_df_ram1_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fifo_entry_t              wr_entry,
    input  logic                     pop,
    output fifo_entry_t              rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/rec_df_ram1_reader.sv
// Deblocking-filter-side reader for the 96x32 reconstruction-to-DF buffer.
// On mb_start it reads words 0..95 in order from a single-port RAM and
// streams them to the filter with component tags, pulsing mb_done once the
// last word has been accepted and the buffer may be overwritten.
//   clk, reset  : clock, asynchronous active-high reset
//   mb_start    : buffer holds a complete macroblock (pulse)
//   busy        : accepted mb_start through the mb_done cycle
//   start_err   : mb_start arrived while not idle (pulse)
//   mb_done     : last word accepted (pulse)
//   ram_cs_n, ram_wr, ram_addr, ram_dout : RAM read port
//   df          : word stream to the filter (master side)
module rec_df_ram1_reader
    import rec_df_ram1_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mb_start,
    output logic                 busy,
    output logic                 start_err,
    output logic                 mb_done,
    output logic                 ram_cs_n,
    output logic                 ram_wr,
    output logic [ADDR_W-1:0]    ram_addr,
    input  logic [31:0]          ram_dout,
    rec_df_ram1_reader_if.master df
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] cap_idx;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    fifo_entry_t       wr_entry;
    fifo_entry_t       rd_entry;
    logic              issue_now;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    count_next;
    logic              credit_next;

    // ISSUE is only ever entered with credit, so every ISSUE cycle is a read.
    assign issue_now = (state == ISSUE);
    assign push      = inflight;
    assign pop       = df.df_valid && df.df_ready;

    // RAM controls are registered, so the credit test looks one cycle ahead:
    // occupancy after this edge plus the read this cycle leaves in flight.
    always_comb begin
        count_next  = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
        credit_next = (count_next + (CNT_W+1)'(issue_now)) < (CNT_W+1)'(FIFO_DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            start_err <= 1'b0;
            mb_done   <= 1'b0;
            ram_cs_n  <= 1'b1;
            ram_addr  <= '0;
            rd_ptr    <= '0;
            cap_idx   <= '0;
            inflight  <= 1'b0;
        end else begin
            start_err <= mb_start && (state != IDLE);
            mb_done   <= 1'b0;
            inflight  <= issue_now;
            if (issue_now)
                cap_idx <= rd_ptr;

            case (state)
                IDLE: begin
                    if (mb_start) begin
                        busy     <= 1'b1;
                        rd_ptr   <= '0;
                        ram_addr <= '0;
                        ram_cs_n <= 1'b0;
                        state    <= PRIME;
                    end
                end
                PRIME: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == LAST_ADDR) begin
                        ram_cs_n <= 1'b1;
                        state    <= DRAIN;
                    end else if (credit_next) begin
                        ram_addr <= rd_ptr + 1'b1;
                    end else begin
                        ram_cs_n <= 1'b1;
                        state    <= STALL;
                    end
                end
                STALL: begin
                    // Dropping cs_n disarmed the RAM output, so re-prime.
                    if (credit_next) begin
                        ram_cs_n <= 1'b0;
                        ram_addr <= rd_ptr;
                        state    <= PRIME;
                    end
                end
                DRAIN: begin
                    // count_next includes any pending capture, so zero means
                    // the final word is being accepted at this edge.
                    if (count_next == '0) begin
                        mb_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = ram_dout;
        wr_entry.idx  = IDX_W'(cap_idx);
        wr_entry.comp = comp_of(32'(cap_idx), LUMA_WORDS, CB_WORDS);
    end

    rec_df_ram1_reader_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (rd_entry),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign ram_wr         = 1'b0;
    assign df.df_valid    = !fifo_empty;
    assign df.df_data     = rd_entry.data;
    assign df.df_word_idx = rd_entry.idx;
    assign df.df_comp     = rd_entry.comp;
    assign df.df_last     = (rd_entry.idx == IDX_W'(NUM_WORDS - 1));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_rec_df_ram1_reader.sv
// Bench for rec_df_ram1_reader: single-port RAM model with prime behaviour,
// expected-word queue filled at each mb_start, and a monitor that checks
// every accepted word against the queue head.
module tb_rec_df_ram1_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  idx;
        logic [1:0]  comp;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        mb_start;
    logic        busy;
    logic        start_err;
    logic        mb_done;
    logic        ram_cs_n;
    logic        ram_wr;
    logic [6:0]  ram_addr;
    logic [31:0] ram_dout;

    rec_df_ram1_reader_if dfi ();

    rec_df_ram1_reader #(
        .FIFO_DEPTH (4),
        .ADDR_W     (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mb_start  (mb_start),
        .busy      (busy),
        .start_err (start_err),
        .mb_done   (mb_done),
        .ram_cs_n  (ram_cs_n),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .df        (dfi)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   xfer_count  = 0;
    int   done_count  = 0;
    int   err_count   = 0;
    int   first_cyc   = 0;
    int   last_cyc    = 0;
    int   max_cnt     = 0;
    exp_t q[$];

    logic [31:0] mem [96];
    logic        armed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int k = 0; k < 96; k++) mem[k] = {4{8'(k)}};
    end

    // Output enable arms on the first selected cycle; data follows one cycle
    // after each address while selected; deselect disarms.
    initial begin
        armed    = 1'b0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (!ram_cs_n && !ram_wr) begin
            if (armed) ram_dout <= mem[ram_addr];
            armed <= 1'b1;
        end else begin
            armed <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_burst();
        exp_t e;
        for (int k = 0; k < 96; k++) begin
            e.data = {4{8'(k)}};
            e.idx  = 7'(k);
            e.comp = (k < 64) ? 2'd0 : (k < 80) ? 2'd1 : 2'd2;
            e.last = (k == 95);
            q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 mb_start = 1'b1;
        @(posedge clk);
        #1 mb_start = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfer_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("xfers_reached", 32'((xfer_count >= target) ? 1 : 0), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int start_cnt = done_count;
        int n = 0;
        while (done_count == start_cnt && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 32'((done_count > start_cnt) ? 1 : 0), 32'd1);
        repeat (5) @(negedge clk);
        chk("done_once", 32'(done_count), 32'(start_cnt + 1));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (32'(dut.fifo_count) > max_cnt) max_cnt = 32'(dut.fifo_count);
                if (dfi.df_valid && dfi.df_ready) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_xfer: got idx %0d, expected no transfer", dfi.df_word_idx);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("df_data@%0d", e.idx), dfi.df_data, e.data);
                        chk($sformatf("df_word_idx@%0d", e.idx), 32'(dfi.df_word_idx), 32'(e.idx));
                        chk($sformatf("df_comp@%0d", e.idx), 32'(dfi.df_comp), 32'(e.comp));
                        chk($sformatf("df_last@%0d", e.idx), 32'(dfi.df_last), 32'(e.last));
                        xfer_count++;
                        if (e.idx == 7'd0) first_cyc = cyc;
                        if (e.last) last_cyc = cyc;
                    end
                end
                if (mb_done) begin
                    done_count++;
                    chk("done_after_last", 32'(cyc), 32'(last_cyc + 1));
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
                if (start_err) err_count++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  d0;
        bit  seen;

        reset           = 1'b1;
        mb_start        = 1'b0;
        dfi.df_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      32'(busy),            32'd0);
        chk("rst_start_err", 32'(start_err),       32'd0);
        chk("rst_mb_done",   32'(mb_done),         32'd0);
        chk("rst_ram_cs_n",  32'(ram_cs_n),        32'd1);
        chk("rst_ram_wr",    32'(ram_wr),          32'd0);
        chk("rst_ram_addr",  32'(ram_addr),        32'd0);
        chk("rst_df_valid",  32'(dfi.df_valid),    32'd0);
        chk("rst_df_data",   dfi.df_data,          32'd0);
        chk("rst_df_idx",    32'(dfi.df_word_idx), 32'd0);
        chk("rst_df_comp",   32'(dfi.df_comp),     32'd0);
        chk("rst_df_last",   32'(dfi.df_last),     32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        dfi.df_ready = 1'b1;

        // Full stream, ready held high: latency 3, one word per cycle.
        push_burst();
        pulse_start();
        @(negedge clk); chk("lat_e0", 32'(dfi.df_valid), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk); chk("lat_e1", 32'(dfi.df_valid), 32'd0);
        @(negedge clk); chk("lat_e2", 32'(dfi.df_valid), 32'd0);
        @(negedge clk); chk("lat_e3", 32'(dfi.df_valid), 32'd1);
        chk("first_idx", 32'(dfi.df_word_idx), 32'd0);
        wait_done(300);
        chk("throughput_span", 32'(last_cyc - first_cyc), 32'd95);

        // Backpressure: ready low for 10 cycles mid-luma.
        base = xfer_count;
        push_burst();
        pulse_start();
        wait_xfers(base + 20, 200);
        @(posedge clk);
        #1 dfi.df_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ram_cs_n) seen = 1'b1;
        end
        chk("stall_cs_high", 32'(seen), 32'd1);
        repeat (6) @(negedge clk);
        chk("held_words",   32'(dut.fifo_count),  32'd4);
        chk("held_valid",   32'(dfi.df_valid),    32'd1);
        chk("held_cs_n",    32'(ram_cs_n),        32'd1);
        chk("held_idx",     32'(dfi.df_word_idx), 32'(q[0].idx));
        chk("held_data",    dfi.df_data,          q[0].data);
        @(posedge clk);
        #1 dfi.df_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (!ram_cs_n) seen = 1'b1;
        end
        chk("reprime_after_release", 32'(seen), 32'd1);
        wait_done(300);

        // Random ready at ~30% duty.
        max_cnt = 0;
        push_burst();
        pulse_start();
        d0 = done_count;
        for (int i = 0; i < 3000 && done_count == d0; i++) begin
            @(posedge clk);
            #1 dfi.df_ready = ($urandom_range(0, 99) < 30);
        end
        dfi.df_ready = 1'b1;
        chk("rand_done_seen", 32'((done_count == d0 + 1) ? 1 : 0), 32'd1);
        repeat (5) @(negedge clk);
        chk("rand_done_once", 32'(done_count), 32'(d0 + 1));
        chk("rand_max_count_le_4", 32'((max_cnt <= 4) ? 1 : 0), 32'd1);
        chk("rand_queue_drained", 32'(q.size()), 32'd0);

        // mb_start while busy at word 40.
        base = xfer_count;
        push_burst();
        pulse_start();
        wait_xfers(base + 40, 200);
        pulse_start();
        @(negedge clk);
        chk("start_err_pulse", 32'(start_err), 32'd1);
        chk("start_err_busy",  32'(busy),      32'd1);
        @(negedge clk);
        chk("start_err_clear", 32'(start_err), 32'd0);
        wait_done(300);
        push_burst();
        pulse_start();
        wait_done(300);
        chk("start_err_total", 32'(err_count), 32'd1);

        // Reset at word 50, then a clean burst.
        base = xfer_count;
        push_burst();
        pulse_start();
        wait_xfers(base + 50, 200);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy",     32'(busy),            32'd0);
        chk("abort_cs_n",     32'(ram_cs_n),        32'd1);
        chk("abort_ram_addr", 32'(ram_addr),        32'd0);
        chk("abort_valid",    32'(dfi.df_valid),    32'd0);
        chk("abort_data",     dfi.df_data,          32'd0);
        chk("abort_idx",      32'(dfi.df_word_idx), 32'd0);
        chk("abort_mb_done",  32'(mb_done),         32'd0);
        q.delete();
        d0 = done_count;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done",  32'(done_count), 32'(d0));
        chk("abort_idle_cs",  32'(ram_cs_n),   32'd1);
        push_burst();
        pulse_start();
        wait_done(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
